lsm_reg_sequencer: RTL and testbench

- Load/store-multiple (LDM/STM) transfer sequencer; the control-side driver of the register bank's REG_COUNTER, LSM_RD_MUX and WRITE_BACK inputs.
- Walks the 16-bit register list from IR, one register per memory beat, and issues word addresses with a req/ack handshake to the memory interface.
- Generates the base-register writeback value.
- Sits between the control FSM (start/done) and the register bank / memory port.

---
 rtl/lsm_reg_sequencer_if.sv | 32 +++
 rtl/lsm_reg_sequencer.sv | 179 +++++++++++++++++
 tb/tb_lsm_reg_sequencer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsm_reg_sequencer_if.sv
// Signal bundle between the LDM/STM sequencer, the control FSM, the register bank and the memory port.
interface lsm_reg_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              START;
    logic [31:0]       IR;
    logic [ADDR_W-1:0] BASE;
    logic              MEM_ACK;
    logic              BUSY;
    logic              MEM_REQ;
    logic              MEM_WE;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [3:0]        REG_COUNTER;
    logic              LSM_RD_MUX;
    logic              LAST;
    logic              WRITE_BACK;
    logic [ADDR_W-1:0] WB_DATA;
    logic              DONE;
    logic              PC_FLUSH;

    modport master (
        input  START, IR, BASE, MEM_ACK,
        output BUSY, MEM_REQ, MEM_WE, MEM_ADDR, REG_COUNTER, LSM_RD_MUX,
               LAST, WRITE_BACK, WB_DATA, DONE, PC_FLUSH
    );

    modport slave (
        output START, IR, BASE, MEM_ACK,
        input  BUSY, MEM_REQ, MEM_WE, MEM_ADDR, REG_COUNTER, LSM_RD_MUX,
               LAST, WRITE_BACK, WB_DATA, DONE, PC_FLUSH
    );
endinterface

// File: rtl/lsm_reg_sequencer.sv
// LDM/STM sequencer: walks IR[15:0] one register per memory beat and generates the base writeback.
// Build macro LSM_PC_FLUSH_EN enables PC_FLUSH for an LDM whose list includes R15.
module lsm_reg_sequencer #(
    parameter int ADDR_W     = 32,
    parameter int WORD_BYTES = 4
) (
    input  logic                clk,
    input  logic                rst,
    lsm_reg_sequencer_if.master bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_WB   = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(WORD_BYTES);

    state_t            state_r, state_s;
    logic [15:0]       mask_r, mask_s;
    logic              l_r, l_s;
    logic              w_r, w_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic [ADDR_W-1:0] wb_r, wb_s;
    logic [ADDR_W-1:0] span_s;
    logic [4:0]        count_s;
    logic              busy_r, mem_req_r, mem_we_r, rd_mux_r, last_r, write_back_r, done_r;
    logic [3:0]        reg_counter_r;
    logic              unused_ir_s;
`ifdef LSM_PC_FLUSH_EN
    logic              pc_r, pc_s, pc_flush_r;
`endif

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 0; i < 16; i++) begin
            c = c + {4'd0, v[i]};
        end
        return c;
    endfunction

    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
            else      idx = idx;
        end
        return idx;
    endfunction

    assign unused_ir_s = ^{bus.IR[31:25], bus.IR[22], bus.IR[19:16]};

    // Next-state logic: list latch, start/writeback address arithmetic and beat advance
    always_comb begin
        state_s = state_r;
        mask_s  = mask_r;
        l_s     = l_r;
        w_s     = w_r;
        addr_s  = addr_r;
        wb_s    = wb_r;
`ifdef LSM_PC_FLUSH_EN
        pc_s    = pc_r;
`endif
        count_s = popcount16(bus.IR[15:0]);
        span_s  = ADDR_W'(count_s) * STRIDE;
        case (state_r)
            ST_IDLE: begin
                if (bus.START) begin
                    mask_s = bus.IR[15:0];
                    l_s    = bus.IR[20];
                    w_s    = bus.IR[21];
`ifdef LSM_PC_FLUSH_EN
                    pc_s   = bus.IR[15];
`endif
                    if (bus.IR[23]) wb_s = bus.BASE + span_s;
                    else            wb_s = bus.BASE - span_s;
                    // Decrementing modes still transfer ascending, from the lowest address
                    case ({bus.IR[24], bus.IR[23]})
                        2'b01:   addr_s = bus.BASE;
                        2'b11:   addr_s = bus.BASE + STRIDE;
                        2'b00:   addr_s = bus.BASE - span_s + STRIDE;
                        default: addr_s = bus.BASE - span_s;
                    endcase
                    if (count_s == 5'd0) state_s = ST_FIN;
                    else                 state_s = ST_XFER;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (bus.MEM_ACK) begin
                    mask_s = mask_r & (mask_r - 16'd1);
                    addr_s = addr_r + STRIDE;
                    if (mask_s != 16'd0) state_s = ST_XFER;
                    else if (w_r)        state_s = ST_WB;
                    else                 state_s = ST_FIN;
                end else begin
                    state_s = ST_XFER;
                end
            end
            ST_WB:   state_s = ST_FIN;
            ST_FIN:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Sequencer state registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            mask_r  <= 16'd0;
            l_r     <= 1'b0;
            w_r     <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            wb_r    <= {ADDR_W{1'b0}};
`ifdef LSM_PC_FLUSH_EN
            pc_r    <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            mask_r  <= mask_s;
            l_r     <= l_s;
            w_r     <= w_s;
            addr_r  <= addr_s;
            wb_r    <= wb_s;
`ifdef LSM_PC_FLUSH_EN
            pc_r    <= pc_s;
`endif
        end
    end

    // Output registers, loaded from the next-state view so they line up with state_r
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_r        <= 1'b0;
            mem_req_r     <= 1'b0;
            mem_we_r      <= 1'b0;
            rd_mux_r      <= 1'b0;
            last_r        <= 1'b0;
            write_back_r  <= 1'b0;
            done_r        <= 1'b0;
            reg_counter_r <= 4'd0;
        end else begin
            busy_r        <= (state_s != ST_IDLE);
            mem_req_r     <= (state_s == ST_XFER);
            mem_we_r      <= (state_s == ST_XFER) && !l_s;
            rd_mux_r      <= (state_s == ST_XFER) && l_s;
            last_r        <= (state_s == ST_XFER) && (popcount16(mask_s) == 5'd1);
            write_back_r  <= (state_s == ST_WB);
            done_r        <= (state_s == ST_FIN);
            reg_counter_r <= lowest_set(mask_s);
        end
    end

`ifdef LSM_PC_FLUSH_EN
    // Refetch request coincident with DONE when an LDM loaded R15
    always_ff @(posedge clk) begin
        if (!rst) pc_flush_r <= 1'b0;
        else      pc_flush_r <= (state_s == ST_FIN) && l_s && pc_s;
    end
    assign bus.PC_FLUSH = pc_flush_r;
`else
    assign bus.PC_FLUSH = 1'b0;
`endif

    assign bus.BUSY        = busy_r;
    assign bus.MEM_REQ     = mem_req_r;
    assign bus.MEM_WE      = mem_we_r;
    assign bus.MEM_ADDR    = addr_r;
    assign bus.REG_COUNTER = reg_counter_r;
    assign bus.LSM_RD_MUX  = rd_mux_r;
    assign bus.LAST        = last_r;
    assign bus.WRITE_BACK  = write_back_r;
    assign bus.WB_DATA     = wb_r;
    assign bus.DONE        = done_r;
endmodule

// File: tb/tb_lsm_reg_sequencer.sv
// Self-checking bench for lsm_reg_sequencer: directed scenarios plus randomised transfers
// checked against a register-list/address model.
`timescale 1ns/1ps
module tb_lsm_reg_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

`ifdef LSM_PC_FLUSH_EN
    localparam bit PC_EN = 1'b1;
`else
    localparam bit PC_EN = 1'b0;
`endif

    lsm_reg_sequencer_if #(.ADDR_W(32)) bus ();

    lsm_reg_sequencer #(.ADDR_W(32), .WORD_BYTES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // {BUSY, MEM_REQ, MEM_WE, LSM_RD_MUX, LAST, WRITE_BACK, DONE, PC_FLUSH}
    logic [7:0] flags;
    assign flags = {bus.BUSY, bus.MEM_REQ, bus.MEM_WE, bus.LSM_RD_MUX,
                    bus.LAST, bus.WRITE_BACK, bus.DONE, bus.PC_FLUSH};

    int unsigned m_regs[$];
    logic [31:0] m_addrs[$];
    logic [31:0] m_wb;

    function automatic logic [31:0] mk_ir(input bit p, input bit u, input bit w, input bit l,
                                          input logic [15:0] list);
        return {7'd0, p, u, 1'b0, w, l, 4'd0, list};
    endfunction

    // Reference: ascending register list, lowest address derived from P/U, writeback from U
    task automatic model(input logic [31:0] ir, input logic [31:0] base);
        int n;
        logic [31:0] lo;
        m_regs.delete();
        m_addrs.delete();
        for (int r = 0; r < 16; r++) if (ir[r]) m_regs.push_back(r);
        n = m_regs.size();
        if (ir[23]) begin
            lo   = ir[24] ? base + 32'd4 : base;
            m_wb = base + 32'(4 * n);
        end else begin
            lo   = ir[24] ? base - 32'(4 * n) : base - 32'(4 * n) + 32'd4;
            m_wb = base - 32'(4 * n);
        end
        for (int i = 0; i < n; i++) m_addrs.push_back(lo + 32'(4 * i));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [31:0] ir, input logic [31:0] base);
        bus.START = 1'b1;
        bus.IR    = ir;
        bus.BASE  = base;
        tick();
        bus.START = 1'b0;
        bus.IR    = $urandom;
        bus.BASE  = $urandom;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.START = 1'b0; bus.IR = 32'd0; bus.BASE = 32'd0; bus.MEM_ACK = 1'b0;
        tick(); tick();
        n_checks++; if (flags !== 8'h00) $display("FAIL reset_flags: got %b expected %b", flags, 8'h00); else n_pass++;
        n_checks++; if ({bus.MEM_ADDR, bus.WB_DATA, bus.REG_COUNTER} !== 68'd0)
            $display("FAIL reset_data: got addr %h wb %h rc %0d expected all 0", bus.MEM_ADDR, bus.WB_DATA, bus.REG_COUNTER); else n_pass++;
        rst = 1'b1;
        tick();
        n_checks++; if (flags !== 8'h00) $display("FAIL reset_idle: got %b expected %b", flags, 8'h00); else n_pass++;
    endtask

    task automatic test_stm_ia_wb();
        start_op(mk_ir(1'b0, 1'b1, 1'b1, 1'b0, 16'h000F), 32'h1000);
        bus.MEM_ACK = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (flags !== {5'b11100 | {4'd0, k == 3}, 3'b000})
                $display("FAIL stm_flags beat %0d: got %b expected %b", k, flags, {5'b11100 | {4'd0, k == 3}, 3'b000}); else n_pass++;
            n_checks++; if (bus.REG_COUNTER !== 4'(k) || bus.MEM_ADDR !== 32'h1000 + 32'(4 * k))
                $display("FAIL stm_beat %0d: got R%0d@%h expected R%0d@%h", k, bus.REG_COUNTER, bus.MEM_ADDR, k, 32'h1000 + 32'(4 * k)); else n_pass++;
            tick();
        end
        n_checks++; if (flags !== 8'b1000_0100 || bus.WB_DATA !== 32'h1010)
            $display("FAIL stm_wb: got %b/%h expected %b/%h", flags, bus.WB_DATA, 8'b1000_0100, 32'h1010); else n_pass++;
        tick();
        n_checks++; if (flags !== 8'b1000_0010) $display("FAIL stm_done: got %b expected %b", flags, 8'b1000_0010); else n_pass++;
        tick();
        n_checks++; if (flags !== 8'h00) $display("FAIL stm_idle: got %b expected %b", flags, 8'h00); else n_pass++;
    endtask

    task automatic test_ldm_db_pc();
        logic [3:0]  regs  [2] = '{4'd0, 4'd15};
        logic [31:0] addrs [2] = '{32'h1FF8, 32'h1FFC};
        start_op(mk_ir(1'b1, 1'b0, 1'b1, 1'b1, 16'h8001), 32'h2000);
        bus.MEM_ACK = 1'b1;
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (flags !== {4'b1101, k == 1, 3'b000})
                $display("FAIL ldm_flags beat %0d: got %b expected %b", k, flags, {4'b1101, k == 1, 3'b000}); else n_pass++;
            n_checks++; if (bus.REG_COUNTER !== regs[k] || bus.MEM_ADDR !== addrs[k])
                $display("FAIL ldm_beat %0d: got R%0d@%h expected R%0d@%h", k, bus.REG_COUNTER, bus.MEM_ADDR, regs[k], addrs[k]); else n_pass++;
            tick();
        end
        n_checks++; if (flags !== 8'b1000_0100 || bus.WB_DATA !== 32'h1FF8)
            $display("FAIL ldm_wb: got %b/%h expected %b/%h", flags, bus.WB_DATA, 8'b1000_0100, 32'h1FF8); else n_pass++;
        tick();
        n_checks++; if (flags !== {7'b1000_001, PC_EN})
            $display("FAIL ldm_done_pcflush: got %b expected %b", flags, {7'b1000_001, PC_EN}); else n_pass++;
        tick();
    endtask

    task automatic test_wait_states();
        start_op(mk_ir(1'b1, 1'b1, 1'b0, 1'b0, 16'h0024), 32'h3000);
        for (int b = 0; b < 2; b++) begin
            for (int w = 0; w < 4; w++) begin
                bus.MEM_ACK = (w == 3);
                n_checks++; if (flags !== {5'b11100 | {4'd0, b == 1}, 3'b000} ||
                                bus.REG_COUNTER !== (b == 0 ? 4'd2 : 4'd5) ||
                                bus.MEM_ADDR !== (b == 0 ? 32'h3004 : 32'h3008))
                    $display("FAIL wait_hold beat %0d cyc %0d: got %b R%0d@%h", b, w, flags, bus.REG_COUNTER, bus.MEM_ADDR); else n_pass++;
                tick();
            end
        end
        bus.MEM_ACK = 1'b0;
        n_checks++; if (flags !== 8'b1000_0010 || bus.WB_DATA !== 32'h3008)
            $display("FAIL wait_done: got %b/%h expected %b/%h", flags, bus.WB_DATA, 8'b1000_0010, 32'h3008); else n_pass++;
        tick();
    endtask

    task automatic test_empty_list();
        bus.MEM_ACK = 1'b1;
        start_op(mk_ir(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000), 32'h4000);
        n_checks++; if (flags !== 8'b1000_0010) $display("FAIL empty_done: got %b expected %b", flags, 8'b1000_0010); else n_pass++;
        tick();
        n_checks++; if (flags !== 8'h00 || bus.WB_DATA !== 32'h4000)
            $display("FAIL empty_idle: got %b/%h expected %b/%h", flags, bus.WB_DATA, 8'h00, 32'h4000); else n_pass++;
        bus.MEM_ACK = 1'b0;
    endtask

    task automatic test_start_ignored();
        start_op(mk_ir(1'b0, 1'b1, 1'b0, 1'b0, 16'h00F0), 32'h5000);
        bus.MEM_ACK = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.START = (k == 1);
            if (k == 1) begin
                bus.IR   = mk_ir(1'b1, 1'b0, 1'b1, 1'b1, 16'h0003);
                bus.BASE = 32'h9000;
            end
            n_checks++; if (bus.REG_COUNTER !== 4'(k + 4) || bus.MEM_ADDR !== 32'h5000 + 32'(4 * k) || flags !== {5'b11100 | {4'd0, k == 3}, 3'b000})
                $display("FAIL ignore_beat %0d: got %b R%0d@%h expected R%0d@%h", k, flags, bus.REG_COUNTER, bus.MEM_ADDR, k + 4, 32'h5000 + 32'(4 * k)); else n_pass++;
            tick();
        end
        bus.START = 1'b0;
        n_checks++; if (flags !== 8'b1000_0010 || bus.WB_DATA !== 32'h5010)
            $display("FAIL ignore_done: got %b/%h expected %b/%h", flags, bus.WB_DATA, 8'b1000_0010, 32'h5010); else n_pass++;
        tick(); tick();
        n_checks++; if (flags !== 8'h00) $display("FAIL ignore_no_restart: got %b expected %b", flags, 8'h00); else n_pass++;
        bus.MEM_ACK = 1'b0;
    endtask

    task automatic test_reset_midop();
        logic [31:0] ir;
        ir = mk_ir(1'b0, 1'b1, 1'b1, 1'b1, 16'h1111);
        start_op(ir, 32'h6000);
        bus.MEM_ACK = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        n_checks++; if (flags !== 8'h00 || {bus.MEM_ADDR, bus.WB_DATA, bus.REG_COUNTER} !== 68'd0)
            $display("FAIL midop_reset: got %b addr %h wb %h rc %0d expected all 0", flags, bus.MEM_ADDR, bus.WB_DATA, bus.REG_COUNTER); else n_pass++;
        tick();
        n_checks++; if (flags !== 8'h00) $display("FAIL midop_abandon: got %b expected %b", flags, 8'h00); else n_pass++;
        start_op(ir, 32'h6000);
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (bus.REG_COUNTER !== 4'(4 * k) || bus.MEM_ADDR !== 32'h6000 + 32'(4 * k) || flags !== {4'b1101, k == 3, 3'b000})
                $display("FAIL midop_rerun beat %0d: got %b R%0d@%h expected R%0d@%h", k, flags, bus.REG_COUNTER, bus.MEM_ADDR, 4 * k, 32'h6000 + 32'(4 * k)); else n_pass++;
            tick();
        end
        n_checks++; if (flags !== 8'b1000_0100 || bus.WB_DATA !== 32'h6010)
            $display("FAIL midop_wb: got %b/%h expected %b/%h", flags, bus.WB_DATA, 8'b1000_0100, 32'h6010); else n_pass++;
        tick();
        n_checks++; if (flags !== 8'b1000_0010) $display("FAIL midop_done: got %b expected %b", flags, 8'b1000_0010); else n_pass++;
        tick();
        bus.MEM_ACK = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] ir, base;
        logic [7:0]  exp_f;
        int          b;
        bit          ack;
        for (int it = 0; it < 60; it++) begin
            ir = $urandom;
            case ($urandom_range(0, 5))
                0:       ir[15:0] = 16'h0000;
                1:       ir[15:0] = 16'hFFFF;
                default: ir[15:0] = ir[15:0];
            endcase
            case ($urandom_range(0, 3))
                0:       base = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                1:       base = 32'($urandom_range(0, 40));
                default: base = $urandom;
            endcase
            model(ir, base);
            bus.MEM_ACK = $urandom_range(0, 1);
            start_op(ir, base);
            b = 0;
            while (b < m_regs.size()) begin
                exp_f = {1'b1, 1'b1, ~ir[20], ir[20], b == m_regs.size() - 1, 3'b000};
                n_checks++; if (flags !== exp_f)
                    $display("FAIL rand_flags op %0d beat %0d: got %b expected %b", it, b, flags, exp_f); else n_pass++;
                n_checks++; if (bus.REG_COUNTER !== 4'(m_regs[b]) || bus.MEM_ADDR !== m_addrs[b])
                    $display("FAIL rand_beat op %0d beat %0d: got R%0d@%h expected R%0d@%h", it, b, bus.REG_COUNTER, bus.MEM_ADDR, m_regs[b], m_addrs[b]); else n_pass++;
                ack = ($urandom_range(0, 2) != 0);
                bus.MEM_ACK = ack;
                tick();
                if (ack) b++;
            end
            bus.MEM_ACK = $urandom_range(0, 1);
            if (ir[21] && m_regs.size() > 0) begin
                n_checks++; if (flags !== 8'b1000_0100 || bus.WB_DATA !== m_wb)
                    $display("FAIL rand_wb op %0d: got %b/%h expected %b/%h", it, flags, bus.WB_DATA, 8'b1000_0100, m_wb); else n_pass++;
                tick();
            end
            exp_f = {7'b1000_001, PC_EN & ir[20] & ir[15]};
            n_checks++; if (flags !== exp_f)
                $display("FAIL rand_done op %0d: got %b expected %b", it, flags, exp_f); else n_pass++;
            tick();
            n_checks++; if (flags !== 8'h00 || bus.WB_DATA !== m_wb)
                $display("FAIL rand_idle op %0d: got %b/%h expected %b/%h", it, flags, bus.WB_DATA, 8'h00, m_wb); else n_pass++;
            if ($urandom_range(0, 1) == 1) tick();
        end
        bus.MEM_ACK = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stm_ia_wb();
        test_ldm_db_pc();
        test_wait_states();
        test_empty_list();
        test_start_ignored();
        test_reset_midop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
